// File: rtl/arc4_decrypt_fsm.sv
// RC4 keystream generation (PRGA) and decryption controller for the ARC4 decryptor.
// Runs after key scheduling: swaps S[i]/S[j], XORs S[S[i]+S[j]] with ciphertext, writes plaintext.
`timescale 1ns/1ps
module arc4_decrypt_fsm #(
  parameter int MSG_LEN  = 32,
  parameter int MSG_AW   = 5,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic              bad,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_wrdata,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [MSG_AW-1:0] enc_addr,
  input  logic [7:0]        enc_q,
  output logic [MSG_AW-1:0] dec_addr,
  output logic [7:0]        dec_wrdata,
  output logic              dec_wren
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_SI, S_WT_SI, S_LD_SI, S_RD_SJ, S_WT_SJ, S_LD_SJ, S_WR_SI,
    S_WR_SJ, S_RD_F, S_WT_F, S_LD_F, S_WR_DEC, S_NEXT, S_DONE
  } state_t;

  localparam logic [MSG_AW-1:0] LAST_K = MSG_AW'(MSG_LEN - 1);

  state_t              state_q, state_d;
  logic [7:0]          i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, f_q, f_d, ek_q, ek_d;
  logic [MSG_AW-1:0]   k_q, k_d;
  logic                bad_q, bad_d, done_q, done_d;
  logic [7:0]          s_addr_q, s_addr_d, s_wrdata_q, s_wrdata_d;
  logic                s_wren_q, s_wren_d, dec_wren_q, dec_wren_d;
  logic [MSG_AW-1:0]   enc_addr_q, enc_addr_d, dec_addr_q, dec_addr_d;
  logic [7:0]          dec_wrdata_q, dec_wrdata_d;

  // Accepted plaintext alphabet: space and lowercase letters.
  function automatic logic is_valid(input logic [7:0] b);
    return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
  endfunction

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    f_d     = f_q;
    ek_d    = ek_q;
    k_d     = k_q;
    bad_d   = bad_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        i_d     = 8'd1;
        j_d     = 8'd0;
        k_d     = '0;
        bad_d   = 1'b0;
        state_d = S_RD_SI;
      end
      S_RD_SI: state_d = S_WT_SI;
      S_WT_SI: state_d = S_LD_SI;
      S_LD_SI: begin
        si_d    = s_q;
        j_d     = j_q + s_q;
        state_d = S_RD_SJ;
      end
      S_RD_SJ: state_d = S_WT_SJ;
      S_WT_SJ: state_d = S_LD_SJ;
      S_LD_SJ: begin
        sj_d    = s_q;
        state_d = S_WR_SI;
      end
      S_WR_SI: state_d = S_WR_SJ;
      S_WR_SJ: state_d = S_RD_F;
      S_RD_F:  state_d = S_WT_F;
      S_WT_F:  state_d = S_LD_F;
      S_LD_F: begin
        f_d     = s_q;
        ek_d    = enc_q;
        state_d = S_WR_DEC;
      end
      S_WR_DEC: begin
        if (CHECK_EN && !is_valid(f_q ^ ek_q)) bad_d = 1'b1;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if ((k_q == LAST_K) || bad_q) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + MSG_AW'(1);
          i_d     = i_q + 8'd1;
          state_d = S_RD_SI;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned with that state.
    s_addr_d     = '0;
    s_wrdata_d   = '0;
    s_wren_d     = 1'b0;
    enc_addr_d   = '0;
    dec_addr_d   = '0;
    dec_wrdata_d = '0;
    dec_wren_d   = 1'b0;
    done_d       = 1'b0;
    unique case (state_d)
      S_RD_SI, S_WT_SI, S_LD_SI: s_addr_d = i_d;
      S_RD_SJ, S_WT_SJ, S_LD_SJ: s_addr_d = j_d;
      S_WR_SI: begin
        s_addr_d   = i_d;
        s_wrdata_d = sj_d;
        s_wren_d   = 1'b1;
      end
      S_WR_SJ: begin
        s_addr_d   = j_d;
        s_wrdata_d = si_d;
        s_wren_d   = 1'b1;
      end
      S_RD_F, S_WT_F, S_LD_F: begin
        s_addr_d   = si_d + sj_d;
        enc_addr_d = k_d;
      end
      S_WR_DEC: begin
        dec_addr_d   = k_d;
        dec_wrdata_d = f_d ^ ek_d;
        dec_wren_d   = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      i_q          <= '0;
      j_q          <= '0;
      si_q         <= '0;
      sj_q         <= '0;
      f_q          <= '0;
      ek_q         <= '0;
      k_q          <= '0;
      bad_q        <= 1'b0;
      done_q       <= 1'b0;
      s_addr_q     <= '0;
      s_wrdata_q   <= '0;
      s_wren_q     <= 1'b0;
      enc_addr_q   <= '0;
      dec_addr_q   <= '0;
      dec_wrdata_q <= '0;
      dec_wren_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      j_q          <= j_d;
      si_q         <= si_d;
      sj_q         <= sj_d;
      f_q          <= f_d;
      ek_q         <= ek_d;
      k_q          <= k_d;
      bad_q        <= bad_d;
      done_q       <= done_d;
      s_addr_q     <= s_addr_d;
      s_wrdata_q   <= s_wrdata_d;
      s_wren_q     <= s_wren_d;
      enc_addr_q   <= enc_addr_d;
      dec_addr_q   <= dec_addr_d;
      dec_wrdata_q <= dec_wrdata_d;
      dec_wren_q   <= dec_wren_d;
    end
  end

  assign done       = done_q;
  assign bad        = bad_q;
  assign s_addr     = s_addr_q;
  assign s_wrdata   = s_wrdata_q;
  assign s_wren     = s_wren_q;
  assign enc_addr   = enc_addr_q;
  assign dec_addr   = dec_addr_q;
  assign dec_wrdata = dec_wrdata_q;
  assign dec_wren   = dec_wren_q;

endmodule

// File: tb/tb_arc4_decrypt_fsm.sv
// Bench for arc4_decrypt_fsm: two instances (validity check off/on) with 2-cycle-latency memory
// models, compared against an RC4 PRGA reference model over directed and random key states.
`timescale 1ns/1ps
module tb_arc4_decrypt_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       start      [2];
  logic       done_o     [2];
  logic       bad_o      [2];
  logic [7:0] s_addr     [2];
  logic [7:0] s_wrdata   [2];
  logic       s_wren     [2];
  logic [7:0] s_q        [2];
  logic [4:0] enc_addr   [2];
  logic [7:0] enc_q      [2];
  logic [4:0] dec_addr   [2];
  logic [7:0] dec_wrdata [2];
  logic       dec_wren   [2];

  logic [7:0] s_mem   [2][256];
  logic [7:0] enc_mem [2][32];
  logic [7:0] dec_mem [2][32];
  logic [7:0] s_aq    [2];
  logic [4:0] e_aq    [2];
  logic [1:0] s_load;
  logic [1:0] d_clr;
  logic [7:0] s_init_val [256];

  logic [7:0] m_s   [256];
  logic [7:0] m_enc [32];
  logic [7:0] m_dec [32];
  logic [7:0] ks    [32];
  logic [7:0] pt    [32];
  int         m_nwr;
  bit         m_bad;

  int n_chk;
  int n_pass;

  always #5 clk = ~clk;

  arc4_decrypt_fsm #(.MSG_LEN(32), .MSG_AW(5), .CHECK_EN(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .done(done_o[0]), .bad(bad_o[0]),
    .s_addr(s_addr[0]), .s_wrdata(s_wrdata[0]), .s_wren(s_wren[0]), .s_q(s_q[0]),
    .enc_addr(enc_addr[0]), .enc_q(enc_q[0]), .dec_addr(dec_addr[0]),
    .dec_wrdata(dec_wrdata[0]), .dec_wren(dec_wren[0])
  );

  arc4_decrypt_fsm #(.MSG_LEN(32), .MSG_AW(5), .CHECK_EN(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .done(done_o[1]), .bad(bad_o[1]),
    .s_addr(s_addr[1]), .s_wrdata(s_wrdata[1]), .s_wren(s_wren[1]), .s_q(s_q[1]),
    .enc_addr(enc_addr[1]), .enc_q(enc_q[1]), .dec_addr(dec_addr[1]),
    .dec_wrdata(dec_wrdata[1]), .dec_wren(dec_wren[1])
  );

  // Memories with registered address and registered output.
  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (s_load[n]) begin
        for (int x = 0; x < 256; x++) s_mem[n][x] <= s_init_val[x];
      end else if (s_wren[n]) begin
        s_mem[n][s_addr[n]] <= s_wrdata[n];
      end
      if (d_clr[n]) begin
        for (int x = 0; x < 32; x++) dec_mem[n][x] <= 8'hEE;
      end else if (dec_wren[n]) begin
        dec_mem[n][dec_addr[n]] <= dec_wrdata[n];
      end
      s_aq[n]  <= s_addr[n];
      s_q[n]   <= s_mem[n][s_aq[n]];
      e_aq[n]  <= enc_addr[n];
      enc_q[n] <= enc_mem[n][e_aq[n]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Plain RC4 PRGA over a copy of the initial S, stopping after the first invalid byte when checking.
  function automatic void ref_run(input bit chk_en);
    logic [7:0] i, j, t, idx, p;
    for (int x = 0; x < 256; x++) m_s[x] = s_init_val[x];
    i = 8'd0;
    j = 8'd0;
    m_nwr = 0;
    m_bad = 1'b0;
    for (int k = 0; k < 32 && !m_bad; k++) begin
      i = i + 8'd1;
      j = j + m_s[i];
      t = m_s[i];
      m_s[i] = m_s[j];
      m_s[j] = t;
      idx = m_s[i] + m_s[j];
      p = m_s[idx] ^ m_enc[k];
      m_dec[k] = p;
      m_nwr++;
      if (chk_en && !(p == 8'h20 || (p >= 8'h61 && p <= 8'h7A))) m_bad = 1'b1;
    end
  endfunction

  task automatic set_identity();
    for (int x = 0; x < 256; x++) s_init_val[x] = 8'(x);
    for (int k = 0; k < 32; k++) m_enc[k] = 8'h00;
  endtask

  task automatic load(input int n);
    for (int k = 0; k < 32; k++) enc_mem[n][k] = m_enc[k];
    @(negedge clk);
    s_load[n] = 1'b1;
    d_clr[n]  = 1'b1;
    @(negedge clk);
    s_load[n] = 1'b0;
    d_clr[n]  = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("%s_ctl%0d", tag, n),
          {18'd0, done_o[n], bad_o[n], s_wren[n], dec_wren[n], enc_addr[n], dec_addr[n]}, 32'd0);
      chk($sformatf("%s_dat%0d", tag, n), {8'd0, s_addr[n], s_wrdata[n], dec_wrdata[n]}, 32'd0);
    end
  endtask

  // Caller positions time just after a rising edge; reset lands mid-cycle.
  task automatic do_reset(input string tag);
    int act;
    #3;
    reset    = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    #1;
    chk_quiet(tag);
    act = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (s_wren[0] | s_wren[1] | dec_wren[0] | dec_wren[1] | done_o[0] | done_o[1]) act++;
    end
    chk($sformatf("%s_held", tag), act, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One run on instance n, compared against the current reference results.
  task automatic run(input int n, input bit hold, input bit swapchk, input string tag);
    int exp_done, win, dcyc, dcnt, wcnt, terr, bad_done, bad_idle, bad_rs, sa_rs, mism;
    exp_done = 1 + 13 * m_nwr;
    win      = hold ? exp_done + 8 : exp_done + 20;
    dcyc = -1; dcnt = 0; wcnt = 0; terr = 0;
    bad_done = -1; bad_idle = -1; bad_rs = -1; sa_rs = -1;
    @(negedge clk);
    start[n] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start[n] = 1'b0;
    for (int cyc = 1; cyc <= win; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk);
        #1;
      end
      if (cyc <= exp_done + 5) begin
        if (done_o[n]) begin
          dcnt++;
          if (dcyc < 0) dcyc = cyc;
        end
        if (dec_wren[n]) begin
          wcnt++;
          if ((cyc - 1) % 13 != 11) terr++;
        end
        if (s_wren[n] && ((cyc - 1) % 13 != 6) && ((cyc - 1) % 13 != 7)) terr++;
      end
      if (cyc == exp_done) bad_done = int'(bad_o[n]);
      if (cyc == exp_done + 1) bad_idle = int'(bad_o[n]);
      if (cyc == exp_done + 2) begin
        bad_rs = int'(bad_o[n]);
        sa_rs  = int'(s_addr[n]);
      end
      if (swapchk && cyc == 27) begin
        chk($sformatf("%s_swap_s1", tag), s_mem[n][1], 8'h01);
        chk($sformatf("%s_swap_s2", tag), s_mem[n][2], 8'h03);
        chk($sformatf("%s_swap_s3", tag), s_mem[n][3], 8'h02);
      end
    end
    start[n] = 1'b0;
    chk($sformatf("%s_done_cyc", tag), dcyc, exp_done);
    chk($sformatf("%s_done_cnt", tag), dcnt, 1);
    chk($sformatf("%s_dec_wr_cnt", tag), wcnt, m_nwr);
    chk($sformatf("%s_wren_timing", tag), terr, 0);
    chk($sformatf("%s_bad", tag), bad_done, int'(m_bad));
    for (int k = 0; k < m_nwr; k++) chk($sformatf("%s_dec%0d", tag, k), dec_mem[n][k], m_dec[k]);
    mism = 0;
    for (int k = m_nwr; k < 32; k++) if (dec_mem[n][k] !== 8'hEE) mism++;
    chk($sformatf("%s_untouched", tag), mism, 0);
    if (hold) begin
      chk($sformatf("%s_bad_idle", tag), bad_idle, int'(m_bad));
      chk($sformatf("%s_bad_clr", tag), bad_rs, 0);
      chk($sformatf("%s_restart_addr", tag), sa_rs, 1);
    end else begin
      mism = 0;
      for (int x = 0; x < 256; x++) if (s_mem[n][x] !== m_s[x]) mism++;
      chk($sformatf("%s_s_final", tag), mism, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    reset    = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    s_load   = 2'b00;
    d_clr    = 2'b00;
    for (int n = 0; n < 2; n++) for (int k = 0; k < 32; k++) enc_mem[n][k] = 8'h00;
    #2;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_quiet("idle");

    // Identity S, zero ciphertext, no validity check
    set_identity();
    ref_run(1'b0);
    load(0);
    run(0, 1'b0, 1'b1, "ident");
    chk("ident_dec0_const", dec_mem[0][0], 8'h02);
    chk("ident_dec1_const", dec_mem[0][1], 8'h05);
    chk("ident_bad_end", bad_o[0], 1'b0);

    // Abort on the second byte
    set_identity();
    m_enc[0] = 8'h63;
    ref_run(1'b1);
    load(1);
    run(1, 1'b0, 1'b0, "abort");
    chk("abort_dec0_const", dec_mem[1][0], 8'h61);
    chk("abort_dec1_const", dec_mem[1][1], 8'h05);
    chk("abort_dec2_const", dec_mem[1][2], 8'hEE);
    chk("abort_bad_end", bad_o[1], 1'b1);

    // Reset in cycle 100, then the same run again
    set_identity();
    ref_run(1'b0);
    load(0);
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (99) @(posedge clk);
    do_reset("midrst");
    load(0);
    run(0, 1'b0, 1'b0, "restart");

    // start held high throughout
    set_identity();
    ref_run(1'b0);
    load(0);
    run(0, 1'b1, 1'b0, "hold0");
    @(posedge clk);
    do_reset("hold0_rst");
    set_identity();
    ref_run(1'b1);
    load(1);
    run(1, 1'b1, 1'b0, "hold1");
    @(posedge clk);
    do_reset("hold1_rst");

    // Random permutations and messages
    for (int it = 0; it < 6; it++) begin
      int n;
      n = it % 2;
      for (int x = 0; x < 256; x++) s_init_val[x] = 8'(x);
      for (int x = 255; x > 0; x--) begin
        int r;
        logic [7:0] t;
        r = int'($urandom_range(x, 0));
        t = s_init_val[x];
        s_init_val[x] = s_init_val[r];
        s_init_val[r] = t;
      end
      for (int k = 0; k < 32; k++) m_enc[k] = 8'h00;
      ref_run(1'b0);
      for (int k = 0; k < 32; k++) ks[k] = m_dec[k];
      for (int k = 0; k < 32; k++) begin
        int r;
        r = int'($urandom_range(26, 0));
        if (n == 0) pt[k] = 8'($urandom);
        else pt[k] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
      end
      if (n == 1 && $urandom_range(1, 0) == 1) pt[$urandom_range(31, 0)] = 8'($urandom_range(31, 0));
      for (int k = 0; k < 32; k++) m_enc[k] = ks[k] ^ pt[k];
      ref_run(n == 1);
      load(n);
      run(n, 1'b0, 1'b0, $sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
